ifetch_unit: RTL and testbench

Instruction fetch unit for the MIPS core: owns the program counter, issues word fetches to instruction memory, buffers the returned instruction and presents it (with pre-split `opcode`/`funct` fields) to the decode controller through a valid/ready handshake. It also consumes the controller's `npc_sel` together with the datapath `zero` flag to redirect the PC for `beq` and `j`. It is the producer side of the controller's `opcode`/`funct` inputs and the consumer of its `npc_sel` output.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/ifetch_unit_npc_calc.sv | 27 ++
 rtl/ifetch_unit.sv | 96 +++++++++
 tb/tb_ifetch_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcodes, reset vector and fetch FSM encoding.
package mips_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 6;

    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_J     = 6'b000010;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    // Word-aligned byte offset of a 16-bit branch immediate.
    function automatic logic [XLEN-1:0] branch_offset(input logic [15:0] imm);
        return {{(XLEN-18){imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_unit_npc_calc.sv
// Next-PC selection for an accepted instruction: sequential, taken beq or j.
module npc_calc
    import mips_pkg::*;
(
    input  logic [XLEN-1:0] inst_pc,
    input  logic [XLEN-1:0] inst,
    input  logic            npc_sel,
    input  logic            zero,
    output logic [XLEN-1:0] npc_c
);

    logic [XLEN-1:0] pc4;
    logic [OPW-1:0]  op;

    assign pc4 = inst_pc + XLEN'(4);
    assign op  = inst[31:26];

    always_comb begin
        npc_c = pc4;
        if (npc_sel && (op == OP_J)) begin
            npc_c = {pc4[31:28], inst[25:0], 2'b00};
        end else if (npc_sel && (op == OP_BEQ) && zero) begin
            npc_c = pc4 + branch_offset(inst[15:0]);
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: PC register, single-outstanding imem fetch and a
// one-entry instruction buffer handed to decode over valid/ready.
module ifetch_unit
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [OPW-1:0]  opcode,
    output logic [OPW-1:0]  funct,
    output logic [XLEN-1:0] inst_pc,
    input  logic            npc_sel,
    input  logic            zero
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] npc_c;

    npc_calc u_npc_calc (
        .inst_pc (inst_pc_q),
        .inst    (inst_q),
        .npc_sel (npc_sel),
        .zero    (zero),
        .npc_c   (npc_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
        end
    end

    // Fetch sequencing; npc_sel/zero only matter in the accept cycle.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;
        case (state_q)
            ST_FETCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    inst_d    = imem_rdata;
                    inst_pc_d = pc_q;
                    valid_d   = 1'b1;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (valid_q && inst_ready) begin
                    pc_d    = npc_c;
                    valid_d = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Request and valid are masked by rst so they read low in every reset cycle.
    assign imem_req   = (state_q == ST_FETCH) && !rst;
    assign inst_valid = valid_q && !rst;
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign opcode     = inst_q[31:26];
    assign funct      = inst_q[5:0];
    assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed cases plus randomized
// transactions compared against a transaction-level PC model.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] inst_pc;
    logic        npc_sel;
    logic        zero;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    logic [31:0] model_pc;

    always #5 clk = ~clk;

    ifetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .opcode      (opcode),
        .funct       (funct),
        .inst_pc     (inst_pc),
        .npc_sel     (npc_sel),
        .zero        (zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural next-PC rule, written as plain address arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] w,
                                             input logic sel, input logic z);
        logic [31:0] pc4;
        logic [31:0] imm;
        pc4 = pc + 32'd4;
        imm = {{16{w[15]}}, w[15:0]};
        if (sel && w[31:26] == 6'd2)
            return (pc4 & 32'hF000_0000) | (32'(w[25:0]) * 32'd4);
        if (sel && w[31:26] == 6'd4 && z)
            return pc4 + imm * 32'd4;
        return pc4;
    endfunction

    // One full fetch/response/hold/accept transaction starting in a FETCH cycle.
    task automatic do_inst(input logic [31:0] w, input int k, input int stall,
                           input logic sel, input logic z, input bit stray);
        check("fetch_req", 32'(imem_req), 32'd1);
        check("fetch_addr", imem_addr, model_pc);
        imem_rvalid = 1'b0;
        tick();
        for (int i = 0; i < k - 1; i++) begin
            check("wait_req", 32'(imem_req), 32'd0);
            check("wait_valid", 32'(inst_valid), 32'd0);
            imem_rdata = $urandom;
            tick();
        end
        imem_rvalid = 1'b1;
        imem_rdata  = w;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        check("hold_valid", 32'(inst_valid), 32'd1);
        check("hold_inst", inst, w);
        check("hold_opcode", 32'(opcode), 32'(w[31:26]));
        check("hold_funct", 32'(funct), 32'(w[5:0]));
        check("hold_inst_pc", inst_pc, model_pc);
        for (int i = 0; i < stall; i++) begin
            inst_ready  = 1'b0;
            npc_sel     = 1'($urandom);
            zero        = 1'($urandom);
            imem_rvalid = stray ? 1'($urandom) : 1'b0;
            imem_rdata  = $urandom;
            tick();
            check("stall_valid", 32'(inst_valid), 32'd1);
            check("stall_inst", inst, w);
            check("stall_inst_pc", inst_pc, model_pc);
            check("stall_req", 32'(imem_req), 32'd0);
        end
        imem_rvalid = 1'b0;
        inst_ready  = 1'b1;
        npc_sel     = sel;
        zero        = z;
        tick();
        inst_ready  = 1'b0;
        npc_sel     = 1'($urandom);
        zero        = 1'($urandom);
        model_pc    = ref_next(model_pc, w, sel, z);
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return {6'd4, 10'($urandom), 16'($urandom)};
            1:       return {6'd2, 26'($urandom)};
            2:       return {6'd0, 20'($urandom), 6'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst         = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        inst_ready  = 1'b0;
        npc_sel     = 1'b0;
        zero        = 1'b0;
        model_pc    = 32'h0000_3000;

        tick();
        tick();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        rst = 1'b0;
        #1;

        do_inst(32'h0022_1821, 1, 0, 1'b0, 1'b0, 1'b0);
        check("seq_next", imem_addr, 32'h0000_3004);
        do_inst(32'h0000_0000, 3, 5, 1'b0, 1'b0, 1'b1);
        check("bp_next", imem_addr, 32'h0000_3008);
        do_inst(32'h1000_FFFF, 1, 0, 1'b1, 1'b1, 1'b0);
        check("beq_taken", imem_addr, 32'h0000_3008);
        do_inst(32'h1000_FFFF, 1, 0, 1'b0, 1'b1, 1'b0);
        check("beq_nosel", imem_addr, 32'h0000_300C);
        do_inst(32'h0800_0C02, 1, 0, 1'b1, 1'b0, 1'b0);
        check("j_back", imem_addr, 32'h0000_3008);
        do_inst(32'h1000_FFFF, 2, 0, 1'b1, 1'b0, 1'b0);
        check("beq_zero0", imem_addr, 32'h0000_300C);
        do_inst(32'h0000_0000, 1, 0, 1'b0, 1'b0, 1'b0);
        check("seq_3010", imem_addr, 32'h0000_3010);
        do_inst(32'h0800_0C00, 1, 0, 1'b1, 1'b0, 1'b0);
        check("j_3000", imem_addr, 32'h0000_3000);
        do_inst(32'h1000_8000, 1, 0, 1'b1, 1'b1, 1'b0);
        check("beq_neg", imem_addr, 32'hFFFE_3004);
        do_inst(32'h0BFF_FFFF, 1, 0, 1'b1, 1'b0, 1'b0);
        check("j_top", imem_addr, 32'hFFFF_FFFC);
        do_inst(32'h0000_0000, 1, 0, 1'b0, 1'b0, 1'b0);
        check("wrap", imem_addr, 32'h0000_0000);

        // Reset while waiting for a response, then a stray response during FETCH.
        check("mw_req", 32'(imem_req), 32'd1);
        tick();
        rst = 1'b1;
        #1;
        check("mw_rst_req", 32'(imem_req), 32'd0);
        check("mw_rst_valid", 32'(inst_valid), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("mw_req2", 32'(imem_req), 32'd1);
        check("mw_addr", imem_addr, 32'h0000_3000);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        check("mw_stray_valid", 32'(inst_valid), 32'd0);
        tick();
        check("mw_wait_valid", 32'(inst_valid), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0020;
        tick();
        imem_rvalid = 1'b0;
        check("mw_valid", 32'(inst_valid), 32'd1);
        check("mw_inst", inst, 32'h0000_0020);
        check("mw_inst_pc", inst_pc, 32'h0000_3000);
        inst_ready = 1'b1;
        npc_sel    = 1'b0;
        tick();
        inst_ready = 1'b0;
        model_pc   = 32'h0000_3004;

        for (int n = 0; n < 300; n++) begin
            do_inst(rand_word(), $urandom_range(1, 4), $urandom_range(0, 3),
                    1'($urandom), 1'($urandom), 1'b1);
        end
        check("final_addr", imem_addr, model_pc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
